// File: rtl/axi_rd_req_tracker_pkg.sv
// axi_rd_req_tracker_pkg: shared grant-decode helpers and refresh-mode encoding
package axi_rd_req_tracker_pkg;
  localparam int MAX_MST = 16;
  typedef enum int {REFRE_ALL = 0, REFRE_LAST = 1} refre_mode_e;
  function automatic logic is_onehot(input logic [MAX_MST-1:0] v);
    return (v != '0) && ((v & (v - MAX_MST'(1))) == '0);
  endfunction
  function automatic logic [3:0] oh2idx(input logic [MAX_MST-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MST; i++) idx = v[i] ? (idx | 4'(i)) : idx;
    return idx;
  endfunction
endpackage

// File: rtl/axi_rd_req_tracker_if.sv
// axi_rd_req_tracker_if: AR/R handshake and arbiter request bundle for the read tracker
interface axi_rd_req_tracker_if #(parameter int N_MST = 3);
  logic [N_MST-1:0] m_arvalid;
  logic [N_MST-1:0] rd_grant;
  logic [N_MST-1:0] rd_req;
  logic s_arvalid;
  logic m_arready;
  logic m_rvalid;
  logic m_rlast;
  logic s_rready;
  logic rd_reg_flag;
  logic rd_state_refre;
  modport slave (
    input  m_arvalid, rd_grant, s_arvalid, m_arready, m_rvalid, m_rlast, s_rready, rd_reg_flag,
    output rd_req, rd_state_refre
  );
  modport master (
    output m_arvalid, rd_grant, s_arvalid, m_arready, m_rvalid, m_rlast, s_rready, rd_reg_flag,
    input  rd_req, rd_state_refre
  );
endinterface

// File: rtl/axi_rd_req_tracker_cnt.sv
// axi_rd_outstd_cnt: per-master saturating outstanding-burst counter with pending-AR bit
module axi_rd_outstd_cnt #(
  parameter int MAX_OUTSTD = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTD + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rstn,
  input  logic             arvalid,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             req_next,
  output logic             ovf,
  output logic             unf
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTD);
  logic             pend;
  logic             pend_next;
  logic [CNT_W-1:0] cnt_next;
  always_comb begin
    ovf       = inc & ~dec & (cnt == CNT_MAX);
    unf       = dec & ~inc & (cnt == '0);
    cnt_next  = (inc & ~dec & ~ovf) ? cnt + CNT_W'(1) :
                (dec & ~inc & ~unf) ? cnt - CNT_W'(1) : cnt;
    pend_next = arvalid | (pend & ~inc);
    req_next  = pend_next | (cnt_next != '0);
  end
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      pend <= pend_next;
    end
  end
endmodule

// File: rtl/axi_rd_req_tracker.sv
// axi_rd_req_tracker: per-master read request tracking, arbiter refresh, grant watchdog and sticky errors
module axi_rd_req_tracker
  import axi_rd_req_tracker_pkg::*;
#(
  parameter int N_MST       = 3,
  parameter int MAX_OUTSTD  = 4,
  parameter int REFRE_MODE  = 0,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CNT_W      = $clog2(MAX_OUTSTD + 1)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rstn,
  axi_rd_req_tracker_if.slave    bus,
  input  logic                   err_clr,
  output logic [N_MST*CNT_W-1:0] rd_outstd_cnt,
  output logic                   rd_timeout,
  output logic                   err_ovf,
  output logic                   err_unf,
  output logic                   err_grant
);
  localparam int IDX_W  = N_MST > 1 ? $clog2(N_MST) : 1;
  localparam int WD_LIM = TIMEOUT_CYC > 0 ? TIMEOUT_CYC : 1;
  localparam int WD_W   = $clog2(WD_LIM + 1);
  localparam logic WD_EN = TIMEOUT_CYC > 0;
  logic [MAX_MST-1:0] grant_ext;
  logic               g_valid;
  logic [IDX_W-1:0]   g;
  logic               ar_hs;
  logic               r_done;
  logic               beat;
  logic [CNT_W-1:0]   cnt_a [N_MST];
  logic [CNT_W-1:0]   cnt_g;
  logic [N_MST-1:0]   req_next;
  logic [N_MST-1:0]   ovf_v;
  logic [N_MST-1:0]   unf_v;
  logic [N_MST-1:0]   grant_q;
  logic [WD_W-1:0]    wd;
  logic               wd_clr;
  assign grant_ext = MAX_MST'(bus.rd_grant);
  assign g_valid   = is_onehot(grant_ext);
  assign g         = IDX_W'(oh2idx(grant_ext));
  assign ar_hs     = bus.s_arvalid & bus.m_arready & g_valid;
  assign r_done    = bus.m_rvalid & bus.m_rlast & bus.s_rready & ~bus.rd_reg_flag & g_valid;
  assign beat      = bus.m_rvalid & bus.s_rready;
  assign cnt_g     = cnt_a[g];
  for (genvar i = 0; i < N_MST; i++) begin : g_mst
    axi_rd_outstd_cnt #(.MAX_OUTSTD(MAX_OUTSTD), .CNT_W(CNT_W)) u_cnt (
      .sys_clk  (sys_clk),
      .sys_rstn (sys_rstn),
      .arvalid  (bus.m_arvalid[i]),
      .inc      (ar_hs & (g == IDX_W'(i))),
      .dec      (r_done & (g == IDX_W'(i))),
      .cnt      (cnt_a[i]),
      .req_next (req_next[i]),
      .ovf      (ovf_v[i]),
      .unf      (unf_v[i])
    );
    assign rd_outstd_cnt[i*CNT_W +: CNT_W] = cnt_a[i];
  end
  assign bus.rd_state_refre = r_done & ~ar_hs & ((REFRE_MODE == REFRE_ALL) || (cnt_g == CNT_W'(1)));
  // watchdog restarts whenever the granted master makes R progress or loses its grant/bursts
  assign wd_clr = beat | (bus.rd_grant != grant_q) | ~g_valid | (cnt_g == '0);
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      bus.rd_req <= '0;
      grant_q    <= '0;
      wd         <= '0;
      rd_timeout <= 1'b0;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
      err_grant  <= 1'b0;
    end else begin
      bus.rd_req <= req_next;
      grant_q    <= bus.rd_grant;
      wd         <= (!WD_EN || wd_clr) ? '0 : (wd == WD_W'(WD_LIM)) ? wd : wd + WD_W'(1);
      rd_timeout <= WD_EN & ~wd_clr & (wd == WD_W'(WD_LIM - 1));
      err_ovf    <= (|ovf_v) | (err_ovf & ~err_clr);
      err_unf    <= (|unf_v) | (err_unf & ~err_clr);
      err_grant  <= ((grant_ext != '0) & ~g_valid) | (err_grant & ~err_clr);
    end
  end
endmodule

// File: tb/tb_axi_rd_req_tracker.sv
// tb_axi_rd_req_tracker: directed table plus watchdog and async-reset sequences on mode-0/mode-1 trackers
module tb_axi_rd_req_tracker;
  localparam logic [6:0] HS = 7'b1100000;
  localparam logic [6:0] BT = 7'b0010100;
  localparam logic [6:0] LS = 7'b0011100;
  localparam logic [6:0] RF = 7'b0000010;
  localparam logic [6:0] EC = 7'b0000001;
  typedef struct {
    logic [2:0] av;
    logic [2:0] gr;
    logic [6:0] ctl;
    logic [2:0] req;
    logic [2:0] c0;
    logic [2:0] c1;
    logic [2:0] c2;
    logic [1:0] rfr;
    logic [2:0] err;
  } vec_t;
  logic sys_clk = 1'b0;
  logic sys_rstn = 1'b0;
  logic [2:0] av = '0, gr = '0;
  logic arv = 0, ardy = 0, rv = 0, rl = 0, rr = 0, rf = 0, ec = 0;
  logic [8:0] cnt0, cnt1;
  logic to0, to1, ovf0, ovf1, unf0, unf1, eg0, eg1;
  int n_chk = 0;
  int n_bad = 0;
  vec_t tbl[$];
  always #5 sys_clk = ~sys_clk;
  axi_rd_req_tracker_if #(.N_MST(3)) bus0 ();
  axi_rd_req_tracker_if #(.N_MST(3)) bus1 ();
  always_comb begin
    bus0.m_arvalid = av; bus0.rd_grant = gr; bus0.s_arvalid = arv; bus0.m_arready = ardy;
    bus0.m_rvalid = rv; bus0.m_rlast = rl; bus0.s_rready = rr; bus0.rd_reg_flag = rf;
  end
  always_comb begin
    bus1.m_arvalid = av; bus1.rd_grant = gr; bus1.s_arvalid = arv; bus1.m_arready = ardy;
    bus1.m_rvalid = rv; bus1.m_rlast = rl; bus1.s_rready = rr; bus1.rd_reg_flag = rf;
  end
  axi_rd_req_tracker #(.N_MST(3), .MAX_OUTSTD(4), .REFRE_MODE(0), .TIMEOUT_CYC(8)) dut0 (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .bus(bus0), .err_clr(ec),
    .rd_outstd_cnt(cnt0), .rd_timeout(to0), .err_ovf(ovf0), .err_unf(unf0), .err_grant(eg0)
  );
  axi_rd_req_tracker #(.N_MST(3), .MAX_OUTSTD(4), .REFRE_MODE(1), .TIMEOUT_CYC(8)) dut1 (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .bus(bus1), .err_clr(ec),
    .rd_outstd_cnt(cnt1), .rd_timeout(to1), .err_ovf(ovf1), .err_unf(unf1), .err_grant(eg1)
  );
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] a, input logic [2:0] g, input logic [6:0] c);
    av = a;
    gr = g;
    {arv, ardy, rv, rl, rr, rf, ec} = c;
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk_idle(input string nm, input int idx);
    chk({nm, "_req0"}, idx, 32'(bus0.rd_req), 0);
    chk({nm, "_req1"}, idx, 32'(bus1.rd_req), 0);
    chk({nm, "_cnt"}, idx, 32'(cnt0), 0);
    chk({nm, "_flags"}, idx, 32'({to0, to1, ovf0, unf0, eg0, ovf1, unf1, eg1}), 0);
  endtask
  initial begin
    tbl = '{
      '{3'b000, 3'b000, 7'd0,    3'b000, 3'd0, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b001, 3'b000, 7'd0,    3'b001, 3'd0, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, HS,      3'b001, 3'd1, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, BT,      3'b001, 3'd1, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, BT,      3'b001, 3'd1, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, BT,      3'b001, 3'd1, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, LS,      3'b000, 3'd0, 3'd0, 3'd0, 2'b11, 3'b000},
      '{3'b010, 3'b000, 7'd0,    3'b010, 3'd0, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b010, 3'b010, HS,      3'b010, 3'd0, 3'd1, 3'd0, 2'b00, 3'b000},
      '{3'b010, 3'b010, HS,      3'b010, 3'd0, 3'd2, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b010, HS,      3'b010, 3'd0, 3'd3, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b010, LS,      3'b010, 3'd0, 3'd2, 3'd0, 2'b10, 3'b000},
      '{3'b000, 3'b010, HS | LS, 3'b010, 3'd0, 3'd2, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b010, LS,      3'b010, 3'd0, 3'd1, 3'd0, 2'b10, 3'b000},
      '{3'b000, 3'b010, LS,      3'b000, 3'd0, 3'd0, 3'd0, 2'b11, 3'b000},
      '{3'b100, 3'b000, 7'd0,    3'b100, 3'd0, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b100, HS,      3'b100, 3'd0, 3'd0, 3'd1, 2'b00, 3'b000},
      '{3'b000, 3'b100, LS | RF, 3'b100, 3'd0, 3'd0, 3'd1, 2'b00, 3'b000},
      '{3'b000, 3'b100, LS,      3'b000, 3'd0, 3'd0, 3'd0, 2'b11, 3'b000},
      '{3'b000, 3'b001, LS,      3'b000, 3'd0, 3'd0, 3'd0, 2'b10, 3'b010},
      '{3'b000, 3'b000, EC,      3'b000, 3'd0, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, HS,      3'b001, 3'd1, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, HS,      3'b001, 3'd2, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, HS,      3'b001, 3'd3, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, HS,      3'b001, 3'd4, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, HS,      3'b001, 3'd4, 3'd0, 3'd0, 2'b00, 3'b100},
      '{3'b000, 3'b011, HS | LS, 3'b001, 3'd4, 3'd0, 3'd0, 2'b00, 3'b101},
      '{3'b000, 3'b001, HS | EC, 3'b001, 3'd4, 3'd0, 3'd0, 2'b00, 3'b100},
      '{3'b000, 3'b000, EC,      3'b001, 3'd4, 3'd0, 3'd0, 2'b00, 3'b000},
      '{3'b000, 3'b001, LS,      3'b001, 3'd3, 3'd0, 3'd0, 2'b10, 3'b000},
      '{3'b000, 3'b001, LS,      3'b001, 3'd2, 3'd0, 3'd0, 2'b10, 3'b000},
      '{3'b000, 3'b001, LS,      3'b001, 3'd1, 3'd0, 3'd0, 2'b10, 3'b000},
      '{3'b000, 3'b001, LS,      3'b000, 3'd0, 3'd0, 3'd0, 2'b11, 3'b000}
    };
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rstn = 1'b1;
    tick();
    chk_idle("reset", 0);
    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].gr, tbl[i].ctl);
      @(negedge sys_clk);
      chk("refre_m0", i, 32'(bus0.rd_state_refre), 32'(tbl[i].rfr[1]));
      chk("refre_m1", i, 32'(bus1.rd_state_refre), 32'(tbl[i].rfr[0]));
      tick();
      chk("rd_req_m0", i, 32'(bus0.rd_req), 32'(tbl[i].req));
      chk("rd_req_m1", i, 32'(bus1.rd_req), 32'(tbl[i].req));
      chk("cnt", i, 32'(cnt0), 32'({tbl[i].c2, tbl[i].c1, tbl[i].c0}));
      chk("cnt_m1", i, 32'(cnt1), 32'({tbl[i].c2, tbl[i].c1, tbl[i].c0}));
      chk("errs", i, 32'({ovf0, unf0, eg0}), 32'(tbl[i].err));
    end
    drive(3'b000, 3'b000, 7'd0);
    tick();
    drive(3'b000, 3'b001, HS);
    tick();
    drive(3'b000, 3'b001, 7'd0);
    for (int k = 2; k <= 12; k++) begin
      tick();
      chk("wd_pulse", k, 32'(to0), 32'(k == 9));
    end
    chk("wd_cnt_held", 12, 32'(cnt0), 1);
    drive(3'b000, 3'b001, BT);
    tick();
    chk("wd_beat", 13, 32'(to0), 0);
    drive(3'b000, 3'b001, 7'd0);
    for (int k = 14; k <= 21; k++) begin
      tick();
      chk("wd_restart", k, 32'(to0), 32'(k == 21));
    end
    drive(3'b000, 3'b001, LS);
    tick();
    chk("wd_drain", 0, 32'(cnt0), 0);
    drive(3'b000, 3'b001, HS);
    tick();
    tick();
    chk("mid_cnt", 0, 32'(cnt0), 2);
    chk("mid_req", 0, 32'(bus0.rd_req), 1);
    drive(3'b000, 3'b000, 7'd0);
    #2 sys_rstn = 1'b0;
    #1 chk_idle("async_rst", 0);
    @(negedge sys_clk);
    sys_rstn = 1'b1;
    tick();
    chk_idle("post_rst", 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
